// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and ALU codes for the multicycle MIPS control unit
package mips_ctrl_pkg;

   // One state per control step of the multicycle datapath; encodings 12..15 are unreachable
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUControl encoding understood by the ALU
   localparam logic [2:0] ALUCTL_ADD = 3'b010;
   localparam logic [2:0] ALUCTL_SUB = 3'b110;
   localparam logic [2:0] ALUCTL_AND = 3'b000;
   localparam logic [2:0] ALUCTL_OR  = 3'b001;
   localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - ALUOp/Funct to ALUControl decode with unsupported-funct flag
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_illegal
);

   logic [2:0] funct_ctl;

   // Funct field lookup; unsupported codes fall back to add and raise the flag
   always_comb begin
      funct_ctl     = ALUCTL_ADD;
      funct_illegal = 1'b0;
      case (funct)
         FN_ADD:  funct_ctl = ALUCTL_ADD;
         FN_SUB:  funct_ctl = ALUCTL_SUB;
         FN_AND:  funct_ctl = ALUCTL_AND;
         FN_OR:   funct_ctl = ALUCTL_OR;
         FN_SLT:  funct_ctl = ALUCTL_SLT;
         default: funct_illegal = 1'b1;
      endcase
   end

   // Select the ALU operation; only ALUOp=10 looks at the funct field
   always_comb begin
      case (aluop)
         ALUOP_ADD:   alucontrol = ALUCTL_ADD;
         ALUOP_SUB:   alucontrol = ALUCTL_SUB;
         ALUOP_FUNCT: alucontrol = funct_ctl;
         default:     alucontrol = ALUCTL_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - Moore control FSM for the multicycle MIPS datapath
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter bit ADDI_EN = 1'b1,
   parameter bit JUMP_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       IllegalOp
);

   state_t     state;
   state_t     next_state;
   logic       illegal_dec;
   logic       funct_illegal;
   logic [1:0] aluop;
   logic       memwrite_s;
   logic       irwrite_s;
   logic       regwrite_s;
   logic       pcwrite;
   logic       branch;

   mips_alu_decoder u_alu_decoder (
      .aluop         (aluop),
      .funct         (Funct),
      .alucontrol    (ALUControl),
      .funct_illegal (funct_illegal)
   );

   // State register; reset returns to FETCH immediately, aborting any instruction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= next_state;
   end

   // Next-state sequencing; unsupported opcodes and R-type functs go back to FETCH from DECODE
   always_comb begin
      next_state  = S_FETCH;
      illegal_dec = 1'b0;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_illegal) illegal_dec = 1'b1;
                  else               next_state  = S_RTYPEEX;
               end
               OP_BEQ: next_state = S_BEQEX;
               OP_ADDI: begin
                  if (ADDI_EN) next_state  = S_ADDIEX;
                  else         illegal_dec = 1'b1;
               end
               OP_J: begin
                  if (JUMP_EN) next_state  = S_JEX;
                  else         illegal_dec = 1'b1;
               end
               default: illegal_dec = 1'b1;
            endcase
         end
         S_MEMADR:  next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   next_state = S_MEMWB;
         S_RTYPEEX: next_state = S_RTYPEWB;
         S_ADDIEX:  next_state = S_ADDIWB;
         default:   next_state = S_FETCH;
      endcase
   end

   // Datapath controls decoded from the state alone; unreachable encodings drive everything low
   always_comb begin
      IorD       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      regwrite_s = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      aluop      = ALUOP_ADD;
      PCSrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (state)
         S_FETCH: begin
            irwrite_s = 1'b1;
            ALUSrcB   = 2'b01;
            pcwrite   = 1'b1;
         end
         S_DECODE:  ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD:   IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_RTYPEEX: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            RegDst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_SUB;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB:  regwrite_s = 1'b1;
         S_JEX: begin
            PCSrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are held off for as long as reset is asserted
   assign IRWrite   = irwrite_s & ~reset;
   assign MemWrite  = memwrite_s & ~reset;
   assign RegWrite  = regwrite_s & ~reset;
   assign PCEn      = (pcwrite | (branch & Zero)) & ~reset;
   assign IllegalOp = illegal_dec & ~reset;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for the multicycle MIPS controller
module tb_mips_multicycle_controller;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam int RUN_CYCLES = 1500;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op_a, funct_a, op_b, funct_b;
   logic       zero_a, zero_b;

   logic       iord_a, memw_a, irw_a, regdst_a, m2r_a, regw_a, srca_a, pcen_a, ill_a;
   logic [1:0] srcb_a, pcsrc_a;
   logic [2:0] ctl_a;
   logic       iord_b, memw_b, irw_b, regdst_b, m2r_b, regw_b, srca_b, pcen_b, ill_b;
   logic [1:0] srcb_b, pcsrc_b;
   logic [2:0] ctl_b;

   logic [15:0] vec_a, vec_b;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   int  total = 0;
   int  bad = 0;
   bit  run = 1'b0;
   bit  draining = 1'b0;
   int  mcyc = 0;

   logic [5:0] d_op[9]    = '{LW, SW, RT, BEQ, BEQ, 6'b111111, ADDI, JMP, RT};
   logic [5:0] d_funct[9] = '{6'd0, 6'd0, 6'b100010, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b111000};
   logic       d_zero[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   mips_multicycle_controller dut_a (
      .clk(clk), .reset(reset), .Op(op_a), .Funct(funct_a), .Zero(zero_a),
      .IorD(iord_a), .MemWrite(memw_a), .IRWrite(irw_a), .RegDst(regdst_a),
      .MemtoReg(m2r_a), .RegWrite(regw_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a),
      .ALUControl(ctl_a), .PCSrc(pcsrc_a), .PCEn(pcen_a), .IllegalOp(ill_a)
   );

   mips_multicycle_controller #(.ADDI_EN(1'b0), .JUMP_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .Op(op_b), .Funct(funct_b), .Zero(zero_b),
      .IorD(iord_b), .MemWrite(memw_b), .IRWrite(irw_b), .RegDst(regdst_b),
      .MemtoReg(m2r_b), .RegWrite(regw_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b),
      .ALUControl(ctl_b), .PCSrc(pcsrc_b), .PCEn(pcen_b), .IllegalOp(ill_b)
   );

   assign vec_a = {iord_a, memw_a, irw_a, regdst_a, m2r_a, regw_a, srca_a, srcb_a, ctl_a, pcsrc_a, pcen_a, ill_a};
   assign vec_b = {iord_b, memw_b, irw_b, regdst_b, m2r_b, regw_b, srca_b, srcb_b, ctl_b, pcsrc_b, pcen_b, ill_b};

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic iord, memw, irw, regdst, m2r, regw, srca,
                                      input logic [1:0] srcb, input logic [2:0] ctl,
                                      input logic [1:0] pcsrc, input logic pcen, ill);
      return {iord, memw, irw, regdst, m2r, regw, srca, srcb, ctl, pcsrc, pcen, ill};
   endfunction

   function automatic bit funct_ok(input logic [5:0] f, output logic [2:0] c);
      c = 3'b010;
      case (f)
         6'b100000: c = 3'b010;
         6'b100010: c = 3'b110;
         6'b100100: c = 3'b000;
         6'b100101: c = 3'b001;
         6'b101010: c = 3'b111;
         default:   return 1'b0;
      endcase
      return 1'b1;
   endfunction

   // Reference model: per-cycle control vectors of one instruction, from FETCH to its last step
   task automatic push_instr(input bit which, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input bit addi_en, input bit jump_en, output int len);
      logic [15:0] seq[$];
      logic [2:0]  c;
      bit          fok;
      logic [15:0] dec_ok, dec_bad, exadr;
      fok     = funct_ok(funct, c);
      dec_ok  = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
      dec_bad = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
      exadr   = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
      seq.push_back(mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
      if (op == LW) begin
         seq.push_back(dec_ok);
         seq.push_back(exadr);
         seq.push_back(mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
         seq.push_back(mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0));
      end else if (op == SW) begin
         seq.push_back(dec_ok);
         seq.push_back(exadr);
         seq.push_back(mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
      end else if (op == RT && fok) begin
         seq.push_back(dec_ok);
         seq.push_back(mk(0,0,0,0,0,0,1,2'b00,c,2'b00,0,0));
         seq.push_back(mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0));
      end else if (op == BEQ) begin
         seq.push_back(dec_ok);
         seq.push_back(mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,zero,0));
      end else if (op == ADDI && addi_en) begin
         seq.push_back(dec_ok);
         seq.push_back(exadr);
         seq.push_back(mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0));
      end else if (op == JMP && jump_en) begin
         seq.push_back(dec_ok);
         seq.push_back(mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0));
      end else begin
         seq.push_back(dec_bad);
      end
      len = seq.size();
      foreach (seq[i]) begin
         if (which) qb.push_back(seq[i]);
         else       qa.push_back(seq[i]);
      end
   endtask

   task automatic pick(input int idx, output logic [5:0] op, output logic [5:0] funct, output logic zero);
      logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      if (idx < 9) begin
         op = d_op[idx]; funct = d_funct[idx]; zero = d_zero[idx];
      end else begin
         case ($urandom_range(0, 7))
            0: op = LW;
            1: op = SW;
            2, 7: op = RT;
            3: op = BEQ;
            4: op = ADDI;
            5: op = JMP;
            default: op = 6'($urandom);
         endcase
         funct = ($urandom_range(0, 4) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
         zero  = 1'($urandom);
      end
   endtask

   // Monitor: every cycle each controller presents a control vector; pop and compare
   always @(negedge clk) begin
      if (run) begin
         mcyc++;
         if (qa.size() > 0) chk("outs_a", vec_a, qa.pop_front());
         else if (!draining) begin
            total++; bad++;
            $display("FAIL underflow_a: got no expected entry, required one at cycle %0d", mcyc);
         end
         if (qb.size() > 0) chk("outs_b", vec_b, qb.pop_front());
         else if (!draining) begin
            total++; bad++;
            $display("FAIL underflow_b: got no expected entry, required one at cycle %0d", mcyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish by 200000");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc = 0, rem_a = 0, rem_b = 0, idx_a = 0, idx_b = 0;
      logic [5:0] o, f;
      logic z;
      reset = 1'b1;
      op_a = LW; funct_a = 6'd0; zero_a = 1'b0;
      op_b = LW; funct_b = 6'd0; zero_b = 1'b0;

      // Directed reset check around an lw, reset hits in MEMRD
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_irwrite", {15'd0, irw_a}, 16'd0);
      chk("rst_pcen", {15'd0, pcen_a}, 16'd0);
      chk("rst_regwrite", {15'd0, regw_a}, 16'd0);
      chk("rst_alusrcb", {14'd0, srcb_a}, 16'd1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rel_irwrite", {15'd0, irw_a}, 16'd1);
      chk("rel_pcen", {15'd0, pcen_a}, 16'd1);
      @(negedge clk);
      chk("lw_decode_srcb", {14'd0, srcb_a}, 16'd3);
      @(negedge clk);
      chk("lw_memadr_srcb", {14'd0, srcb_a}, 16'd2);
      @(negedge clk);
      chk("lw_memrd_iord", {15'd0, iord_a}, 16'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_iord", {15'd0, iord_a}, 16'd0);
      chk("abort_srcb", {14'd0, srcb_a}, 16'd1);
      chk("abort_irwrite", {15'd0, irw_a}, 16'd0);
      @(negedge clk);
      chk("abort_regwrite", {15'd0, regw_a}, 16'd0);
      chk("abort_memtoreg", {15'd0, m2r_a}, 16'd0);

      // Scoreboard phase: directed list first, then random instructions
      do begin
         @(posedge clk); #1;
         reset = 1'b0;
         run   = 1'b1;
         if (rem_a == 0 && cyc < RUN_CYCLES) begin
            pick(idx_a, o, f, z); idx_a++;
            op_a = o; funct_a = f; zero_a = z;
            push_instr(1'b0, o, f, z, 1'b1, 1'b1, rem_a);
         end
         if (rem_b == 0 && cyc < RUN_CYCLES) begin
            pick(idx_b, o, f, z); idx_b++;
            op_b = o; funct_b = f; zero_b = z;
            push_instr(1'b1, o, f, z, 1'b0, 1'b0, rem_b);
         end
         if (cyc >= RUN_CYCLES) draining = 1'b1;
         if (rem_a > 0) rem_a--;
         if (rem_b > 0) rem_b--;
         cyc++;
      end while (cyc < RUN_CYCLES || rem_a != 0 || rem_b != 0);
      draining = 1'b1;
      @(negedge clk); #1;
      run = 1'b0;
      chk("leftover_a", 16'(qa.size()), 16'd0);
      chk("leftover_b", 16'(qb.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
